// File: rtl/uart_image_loader.sv
// UART frame receiver that streams one sync-prefixed image into the CNN input buffer.
// Optional trailing XOR check byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_image_loader #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned DEPTH     = 784,
    parameter int unsigned ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned BIT_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BIT_CNT_W-1:0] HALF_LOAD = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] FULL_LOAD = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {FrWaitSync, FrLoad, FrCheck} fr_state_e;
`else
    typedef enum logic [1:0] {FrWaitSync, FrLoad} fr_state_e;
`endif

    logic [1:0]           sync_q, sync_d;
    logic                 prev_q, prev_d;
    logic                 rx_s;
    rx_state_e            rx_state_q, rx_state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;

    fr_state_e            fr_state_q, fr_state_d;
    logic [ADDR_W-1:0]    addr_cnt_q, addr_cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           xor_q, xor_d;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d       = {sync_q[0], rx};
        prev_d       = rx_s;
        rx_state_d   = rx_state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        rx_ferr_d    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (prev_q && !rx_s) begin
                    bit_cnt_d  = HALF_LOAD;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (bit_cnt_q == '0) begin
                    if (rx_s) begin
                        rx_state_d = RxIdle;
                    end else begin
                        bit_cnt_d  = FULL_LOAD;
                        bit_idx_d  = 3'd0;
                        rx_state_d = RxData;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            RxData: begin
                if (bit_cnt_q == '0) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = FULL_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            RxStop: begin
                // Return to idle at mid-stop so a start bit right after it is caught.
                if (bit_cnt_q == '0) begin
                    byte_valid_d = rx_s;
                    rx_ferr_d    = !rx_s;
                    rx_state_d   = RxIdle;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        fr_state_d   = fr_state_q;
        addr_cnt_d   = addr_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        unique case (fr_state_q)
            FrWaitSync: begin
                if (byte_valid_q && shift_q == SYNC_BYTE) begin
                    fr_state_d = FrLoad;
                    addr_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = 8'h00;
`endif
                end
            end
            FrLoad: begin
                if (rx_ferr_q) begin
                    frame_err_d = 1'b1;
                    fr_state_d  = FrWaitSync;
                    addr_cnt_d  = '0;
                end else if (byte_valid_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_cnt_q;
                    wr_data_d = DATA_SIZE'($signed(shift_q));
`ifdef LOADER_CHECKSUM_EN
                    xor_d     = xor_q ^ shift_q;
`endif
                    if (addr_cnt_q == LAST_ADDR) begin
                        addr_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                        fr_state_d = FrCheck;
`else
                        frame_done_d = 1'b1;
                        fr_state_d   = FrWaitSync;
`endif
                    end else begin
                        addr_cnt_d = addr_cnt_q + 1'b1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            FrCheck: begin
                if (rx_ferr_q) begin
                    frame_err_d = 1'b1;
                    fr_state_d  = FrWaitSync;
                end else if (byte_valid_q) begin
                    frame_done_d = (shift_q == xor_q);
                    frame_err_d  = (shift_q != xor_q);
                    fr_state_d   = FrWaitSync;
                end
            end
`endif
            default: fr_state_d = FrWaitSync;
        endcase
        busy_d = (fr_state_d != FrWaitSync);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            rx_state_q   <= RxIdle;
            bit_cnt_q    <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_valid_q <= 1'b0;
            rx_ferr_q    <= 1'b0;
            fr_state_q   <= FrWaitSync;
            addr_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= 8'h00;
`endif
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            rx_state_q   <= rx_state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            rx_ferr_q    <= rx_ferr_d;
            fr_state_q   <= fr_state_d;
            addr_cnt_q   <= addr_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule
